// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide unit for the MIPS datapath.
// mult runs a shift-add loop and div runs a restoring loop. Both loops work on
// operand magnitudes, and a final FIX step applies MIPS signs.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start, op, a, b   - one-cycle request (op 0=mult, 1=div), sampled in IDLE
//   busy, done        - busy while an operation runs; done is a one-cycle pulse
//   hi, lo            - mult: product upper/lower; div: remainder/quotient
//   div_zero          - only with DIV_ZERO_EXC_EN: div by zero completes
//                       immediately, with hi/lo left unchanged
// Optional feature macro: DIV_ZERO_EXC_EN
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef DIV_ZERO_EXC_EN
  ,
  output logic             div_zero
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  // Holds {carry/rem-msb, upper, lower}. For mult: upper = partial product and
  // lower = multiplier. For div: upper = remainder and lower = quotient.
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;  // |a| for mult, |b| for div
  logic               r_op;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
`ifdef DIV_ZERO_EXC_EN
  logic               r_dz_pend;
  logic               r_div_zero;
`endif

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH:0]   w_mul_next;
  logic [2*WIDTH:0]   w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH:0]   w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // The magnitude of the most negative value wraps to itself. That result is
  // correct when it is read as unsigned.
  assign w_a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign w_b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_mul_next = r_acc[0] ? ({w_mul_sum, r_acc[WIDTH-1:0]} >> 1) : (r_acc >> 1);

  assign w_div_sh   = {r_acc[2*WIDTH-1:0], 1'b0};
  assign w_div_diff = w_div_sh[2*WIDTH:WIDTH] - {1'b0, r_mcand};
  assign w_div_next = w_div_diff[WIDTH] ? w_div_sh
                                        : {w_div_diff, w_div_sh[WIDTH-1:1], 1'b1};

  assign w_prod     = r_acc[2*WIDTH-1:0];
  assign w_prod_fix = r_sign_q ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
  assign w_quot_fix = r_sign_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sign_r ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1))
                               : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_op       <= 1'b0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
`ifdef DIV_ZERO_EXC_EN
      r_dz_pend  <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      r_div_zero <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            r_sign_r <= a[WIDTH-1];
            r_cnt    <= '0;
            r_acc    <= {{(WIDTH+1){1'b0}}, (op ? w_a_mag : w_b_mag)};
            r_mcand  <= op ? w_b_mag : w_a_mag;
            r_busy   <= 1'b1;
`ifdef DIV_ZERO_EXC_EN
            r_dz_pend <= op && (b == '0);
            if (op && (b == '0))
              r_state <= S_DONE;
            else
`endif
            r_state  <= op ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_op) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          // done/busy are registered, so the pulse shows in the cycle after DONE
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
          r_div_zero <= r_dz_pend;
          r_dz_pend  <= 1'b0;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
`ifdef DIV_ZERO_EXC_EN
  assign div_zero = r_div_zero;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (WIDTH=32).
// Expected hi/lo values come from 64-bit signed arithmetic in the bench. When an
// operation is issued, its expected result and its start-to-done latency go into
// a queue. Each done pulse pops one entry from that queue and compares against it.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef DIV_ZERO_EXC_EN
  logic         div_zero;
`endif

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
`ifdef DIV_ZERO_EXC_EN
    ,
    .div_zero (div_zero)
`endif
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           ecnt = 0;
  int           drive_ecnt = 0;
  bit           inflight = 1'b0;
  int           n_done = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) ecnt <= ecnt + 1;

  // Monitor: checks busy mid-operation, then compares each done pulse
  // against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    if (inflight && !reset && sb.size() > 0) begin
      rel = ecnt - drive_ecnt;
      if (rel == 1 || rel == sb[0].lat - 1)
        check($sformatf("busy_c%0d", rel), 64'(busy), 64'(1));
    end
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("latency", 64'(ecnt - drive_ecnt), 64'(e.lat));
        check("busy_at_done", 64'(busy), 64'(0));
`ifdef DIV_ZERO_EXC_EN
        check("div_zero", 64'(div_zero), 64'(e.dz));
`endif
        inflight = 1'b0;
      end
    end
  end

  // Issues one operation. poke_at: edge index at which a junk start is
  // sampled (0 = none). reset_at: edge index at which reset is sampled
  // (0 = none); the operation is then expected to be aborted.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int poke_at, input int reset_at);
    exp_t        e;
    longint      sa, sbv, r64;
    logic [63:0] v;
    int          base, waited, rel;
    sa  = longint'($signed(x));
    sbv = longint'($signed(y));
    e.dz  = 1'b0;
    e.lat = 35;
    if (!o) begin
      v = 64'(sa * sbv);
      e.hi = v[63:32];
      e.lo = v[31:0];
    end else if (y == '0) begin
`ifdef DIV_ZERO_EXC_EN
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.dz  = 1'b1;
      e.lat = 2;
`else
      e.hi = x;
      e.lo = x[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
    end else begin
      v   = 64'(sa / sbv);
      r64 = sa % sbv;
      e.lo = v[31:0];
      v   = 64'(r64);
      e.hi = v[31:0];
    end
    if (!e.dz) begin
      m_hi = e.hi;
      m_lo = e.lo;
    end
    @(posedge clk); #2;
    sb.push_back(e);
    inflight   = 1'b1;
    drive_ecnt = ecnt;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    base   = n_done;
    waited = 0;
    while (n_done == base && waited < 100) begin
      rel = ecnt - drive_ecnt;
      if (reset_at != 0 && rel == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        void'(sb.pop_front());
        inflight = 1'b0;
        m_hi = '0;
        m_lo = '0;
        return;
      end
      if (poke_at != 0 && rel == poke_at) begin
        start = 1'b1; op = $urandom_range(0, 1); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #2;
      waited++;
    end
    start = 1'b0;
    if (n_done == base) begin
      check("timeout", 64'(0), 64'(1));
      if (sb.size() > 0) void'(sb.pop_front());
      inflight = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
`ifdef DIV_ZERO_EXC_EN
    check("rst_div_zero", 64'(div_zero), 64'(0));
`endif
    @(posedge clk); #2;
    reset = 1'b0;

    issue(1'b0, 32'd6, 32'hFFFF_FFF9, 0, 0);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    issue(1'b0, 32'd1234, 32'hFFFF_EA00, 10, 0);
    issue(1'b0, 32'hFFFF_0001, 32'd3, 34, 0);
    repeat (40) @(posedge clk);
    issue(1'b1, 32'd1000, 32'd7, 0, 20);
    repeat (40) @(posedge clk);
    issue(1'b0, 32'd3, 32'd5, 0, 0);
    issue(1'b1, 32'd7, 32'd0, 0, 0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd0, 0, 0);
    issue(1'b1, 32'd0, 32'd5, 0, 0);
    issue(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    issue(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 2)
        issue(1'b1, $urandom, $urandom_range(1, 20), 0, 0);
      else
        issue(1'(i % 2), $urandom, $urandom, 0, 0);
    end
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
